// File: rtl/rv_dmem_responder_pkg.sv
// Shared definitions for the uRV data-memory responder: FSM encoding,
// wait-counter sizing and the address range helper.
package rv_dmem_responder_pkg;

   typedef enum logic [1:0] {
      DM_STATE_IDLE   = 2'd0,
      DM_STATE_ACCESS = 2'd1,
      DM_STATE_WAIT   = 2'd2,
      DM_STATE_DONE   = 2'd3
   } dm_state_e;

   localparam int unsigned DM_WAIT_MAX   = 15;
   localparam int unsigned DM_WAIT_CNT_W = 4;

   // True when the byte address lies above the SRAM's word space.
   function automatic logic dm_addr_out_of_range(input logic [31:0] addr,
                                                 input int unsigned addr_width);
      logic [31:0] upper;
      upper = addr >> (addr_width + 2);
      return (upper != 32'd0);
   endfunction

endpackage

// File: rtl/rv_dmem_responder_if.sv
// Bundle of the core-side data-memory handshake and the SRAM port.
// slave: the responder; master: core plus SRAM (or a testbench standing in for both).
interface rv_dmem_responder_if #(
   parameter int unsigned ADDR_WIDTH = 14
);

   logic [31:0]           dm_addr_i;
   logic [31:0]           dm_data_s_i;
   logic [3:0]            dm_data_select_i;
   logic                  dm_load_i;
   logic                  dm_store_i;
   logic [31:0]           dm_data_l_o;
   logic                  dm_load_done_o;
   logic                  dm_store_done_o;
   logic                  dm_busy_o;
   logic                  dm_err_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [31:0]           mem_wdata_o;
   logic [3:0]            mem_we_o;
   logic                  mem_re_o;
   logic [31:0]           mem_rdata_i;

   modport slave (
      input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i, mem_rdata_i,
      output dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_busy_o, dm_err_o,
      output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
   );

   modport master (
      output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i, mem_rdata_i,
      input  dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_busy_o, dm_err_o,
      input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
   );

endinterface

// File: rtl/rv_dmem_responder.sv
// Memory-side responder of the uRV data-memory interface. One access in flight:
// IDLE -> ACCESS (SRAM strobe) -> WAIT (WAIT_STATES cycles) -> DONE (done pulse).
// With WAIT_STATES=0 the SRAM data only arrives in the DONE cycle, so the load
// result is forwarded straight from the SRAM during that cycle and registered after.
module rv_dmem_responder
   import rv_dmem_responder_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned ADDR_WIDTH  = 14
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   rv_dmem_responder_if.slave bus
);

   localparam logic [DM_WAIT_CNT_W-1:0] WAIT_INIT   = 4'(WAIT_STATES);
   localparam bit                       READ_BYPASS = (WAIT_STATES == 0);

   dm_state_e              state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   is_store_q, is_store_d;
   logic                   oor_q, oor_d;
   logic                   collide_q, collide_d;
   logic [31:0]            data_q, data_d;
   logic                   mem_re_q, mem_re_d;
   logic [3:0]             mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [31:0]            mem_wdata_q, mem_wdata_d;
   logic                   load_done_q, load_done_d;
   logic                   store_done_q, store_done_d;
   logic                   err_q, err_d;
   logic                   enter_done;
   logic                   req_oor;
   logic [31:0]            rdata_word;

   assign rdata_word = oor_q ? 32'h0 : bus.mem_rdata_i;

   // Next-state, request capture, SRAM strobes and completion pulses.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      is_store_d   = is_store_q;
      oor_d        = oor_q;
      collide_d    = collide_q;
      data_d       = data_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 4'h0;
      mem_addr_d   = '0;
      mem_wdata_d  = 32'h0;
      load_done_d  = 1'b0;
      store_done_d = 1'b0;
      err_d        = 1'b0;
      enter_done   = 1'b0;
      req_oor      = dm_addr_out_of_range(bus.dm_addr_i, ADDR_WIDTH);

      case (state_q)
         DM_STATE_IDLE: begin
            if (bus.dm_load_i || bus.dm_store_i) begin
               state_d    = DM_STATE_ACCESS;
               is_store_d = bus.dm_store_i;
               collide_d  = bus.dm_load_i && bus.dm_store_i;
               oor_d      = req_oor;
               if (!req_oor) begin
                  mem_addr_d = bus.dm_addr_i[ADDR_WIDTH+1:2];
                  if (bus.dm_store_i) begin
                     mem_we_d    = bus.dm_data_select_i;
                     mem_wdata_d = bus.dm_data_s_i;
                  end else begin
                     mem_re_d = 1'b1;
                  end
               end
            end
         end
         DM_STATE_ACCESS: begin
            cnt_d = WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
               enter_done = 1'b1;
            end else begin
               state_d = DM_STATE_WAIT;
            end
         end
         DM_STATE_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               enter_done = 1'b1;
            end
         end
         DM_STATE_DONE: begin
            state_d = DM_STATE_IDLE;
            if (READ_BYPASS && !is_store_q) begin
               data_d = rdata_word;
            end
         end
         default: state_d = DM_STATE_IDLE;
      endcase

      if (enter_done) begin
         state_d      = DM_STATE_DONE;
         load_done_d  = !is_store_q;
         store_done_d = is_store_q;
         err_d        = oor_q || collide_q;
         if (!READ_BYPASS && !is_store_q) begin
            data_d = rdata_word;
         end
      end
   end

   // State, captured request and registered outputs; reset aborts any access at once.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= DM_STATE_IDLE;
         cnt_q        <= 4'h0;
         is_store_q   <= 1'b0;
         oor_q        <= 1'b0;
         collide_q    <= 1'b0;
         data_q       <= 32'h0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 4'h0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'h0;
         load_done_q  <= 1'b0;
         store_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         is_store_q   <= is_store_d;
         oor_q        <= oor_d;
         collide_q    <= collide_d;
         data_q       <= data_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         load_done_q  <= load_done_d;
         store_done_q <= store_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.dm_data_l_o     = (READ_BYPASS && load_done_q) ? rdata_word : data_q;
   assign bus.dm_load_done_o  = load_done_q;
   assign bus.dm_store_done_o = store_done_q;
   assign bus.dm_busy_o       = (state_q != DM_STATE_IDLE);
   assign bus.dm_err_o        = err_q;
   assign bus.mem_addr_o      = mem_addr_q;
   assign bus.mem_wdata_o     = mem_wdata_q;
   assign bus.mem_we_o        = mem_we_q;
   assign bus.mem_re_o        = mem_re_q;

endmodule
